// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: merges stall requests, turns MEM-stage
// exceptions into a single flush + redirect, and tracks stall watchdog / stall-cycle statistics.
module pipe_stall_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int unsigned WDOG_LIMIT = 1024,
    parameter int unsigned WDOG_W     = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        excp_valid_i,
    input  logic        excp_eret_i,
    input  logic [31:0] excp_epc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        stall_timeout_o,
    output logic [31:0] stall_cycles_o
);

    typedef enum logic {IDLE, DEFER} state_e;

    localparam logic [5:0]        STALL_MEM = 6'b011111;
    localparam logic [5:0]        STALL_EX  = 6'b001111;
    localparam logic [5:0]        STALL_ID  = 6'b000111;
    localparam logic [5:0]        STALL_IF  = 6'b000011;
    localparam logic [WDOG_W-1:0] WD_MAX    = WDOG_W'(WDOG_LIMIT);

    state_e             state_q, state_d;
    logic               eret_q, eret_d;
    logic [31:0]        epc_q, epc_d;
    logic [WDOG_W-1:0]  wd_q, wd_d;
    logic               timeout_q, timeout_d;
    logic [31:0]        cyc_q, cyc_d;
    logic [5:0]         req_stall;

    always_comb begin
        if (stallreq_mem_i)     req_stall = STALL_MEM;
        else if (stallreq_ex_i) req_stall = STALL_EX;
        else if (stallreq_id_i) req_stall = STALL_ID;
        else if (stallreq_if_i) req_stall = STALL_IF;
        else                    req_stall = 6'b000000;
    end

    always_comb begin
        state_d  = state_q;
        eret_d   = eret_q;
        epc_d    = epc_q;
        stall_o  = 6'b000000;
        flush_o  = 1'b0;
        new_pc_o = 32'h0;
        // Outputs are combinational, so reset must mask them in the same cycle.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (excp_valid_i && !stallreq_mem_i) begin
                        flush_o  = 1'b1;
                        new_pc_o = excp_eret_i ? excp_epc_i : EXC_VECTOR;
                    end else if (excp_valid_i) begin
                        stall_o = STALL_MEM;
                        eret_d  = excp_eret_i;
                        epc_d   = excp_epc_i;
                        state_d = DEFER;
                    end else begin
                        stall_o = req_stall;
                    end
                end
                DEFER: begin
                    // Only MEM matters here: the held exception waits for the data bus alone.
                    if (stallreq_mem_i) begin
                        stall_o = STALL_MEM;
                    end else begin
                        flush_o  = 1'b1;
                        new_pc_o = eret_q ? epc_q : EXC_VECTOR;
                        eret_d   = 1'b0;
                        epc_d    = 32'h0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        if (stall_o == 6'b000000 || flush_o) wd_d = '0;
        else if (wd_q == WD_MAX)             wd_d = wd_q;
        else                                 wd_d = wd_q + 1'b1;
        timeout_d = timeout_q | (wd_d == WD_MAX);
        cyc_d     = cyc_q + {31'b0, (stall_o != 6'b000000)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            eret_q    <= 1'b0;
            epc_q     <= 32'h0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            cyc_q     <= 32'h0;
        end else begin
            state_q   <= state_d;
            eret_q    <= eret_d;
            epc_q     <= epc_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            cyc_q     <= cyc_d;
        end
    end

    assign stall_timeout_o = timeout_q;
    assign stall_cycles_o  = cyc_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed vectors with literal checks plus a per-cycle behavioural model.
module tb_pipe_stall_ctrl;

    localparam int          LIMIT = 4;
    localparam logic [31:0] VEC   = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_if = 0, s_id = 0, s_ex = 0, s_mem = 0;
    logic        ev = 0, eret = 0;
    logic [31:0] epc = 32'h0;
    logic [5:0]  stall;
    logic        flush, tout;
    logic [31:0] new_pc, cycles;

    int total = 0;
    int bad   = 0;

    pipe_stall_ctrl #(.EXC_VECTOR(VEC), .WDOG_LIMIT(LIMIT), .WDOG_W(3)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if_i(s_if), .stallreq_id_i(s_id), .stallreq_ex_i(s_ex), .stallreq_mem_i(s_mem),
        .excp_valid_i(ev), .excp_eret_i(eret), .excp_epc_i(epc),
        .stall_o(stall), .flush_o(flush), .new_pc_o(new_pc),
        .stall_timeout_o(tout), .stall_cycles_o(cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a pending exception is just "a redirect target owed once MEM frees up".
    bit          m_pend = 0;
    logic [31:0] m_tgt  = 0;
    int          m_run  = 0;
    bit          m_to   = 0;
    logic [31:0] m_cyc  = 0;
    int          m_nflush = 0;
    int          d_nflush = 0;

    always begin
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        @(negedge clk);
        e_stall = 0; e_flush = 0; e_pc = 0;
        if (!rst) begin
            if (m_pend) begin
                if (s_mem) e_stall = 6'b011111;
                else begin e_flush = 1; e_pc = m_tgt; end
            end else if (ev) begin
                if (s_mem) e_stall = 6'b011111;
                else begin e_flush = 1; e_pc = eret ? epc : VEC; end
            end else begin
                e_stall = s_mem ? 6'b011111 : s_ex ? 6'b001111 : s_id ? 6'b000111 :
                          s_if ? 6'b000011 : 6'b000000;
            end
        end
        chk("m_stall", 32'(stall), 32'(e_stall));
        chk("m_flush", 32'(flush), 32'(e_flush));
        chk("m_new_pc", new_pc, e_pc);
        chk("m_timeout", 32'(tout), 32'(m_to));
        chk("m_cycles", cycles, m_cyc);
        if (flush === 1'b1) d_nflush++;
        if (e_flush) m_nflush++;
        @(posedge clk);
        if (rst) begin
            m_pend = 0; m_tgt = 0; m_run = 0; m_to = 0; m_cyc = 0;
        end else begin
            if (m_pend && !s_mem) m_pend = 0;
            else if (!m_pend && ev && s_mem) begin
                m_pend = 1;
                m_tgt  = eret ? epc : VEC;
            end
            if (e_stall != 0) begin
                m_cyc = m_cyc + 1;
                if (m_run < LIMIT) m_run++;
            end else m_run = 0;
            if (m_run == LIMIT) m_to = 1;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic i_f, input logic i_d, input logic i_e, input logic i_m);
        s_if = i_f; s_id = i_d; s_ex = i_e; s_mem = i_m;
    endtask

    initial begin
        nxt(); nxt();
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_cycles", cycles, 32'h0);
        chk("rst_timeout", 32'(tout), 32'h0);
        nxt();
        rst = 0;

        set_req(1, 0, 1, 0); @(negedge clk); chk("if_ex", 32'(stall), 32'h0F); nxt();
        set_req(0, 1, 0, 0); @(negedge clk); chk("id_only", 32'(stall), 32'h07); nxt();
        set_req(1, 1, 1, 1); @(negedge clk); chk("mem_wins", 32'(stall), 32'h1F); nxt();
        set_req(0, 0, 0, 0); @(negedge clk);
        chk("none_stall", 32'(stall), 32'h0);
        chk("none_flush", 32'(flush), 32'h0);
        chk("cycles_3", cycles, 32'd3);
        nxt();

        ev = 1; eret = 0; @(negedge clk);
        chk("exc_flush", 32'(flush), 32'h1);
        chk("exc_pc", new_pc, 32'hBFC00380);
        chk("exc_stall", 32'(stall), 32'h0);
        nxt();
        ev = 0; @(negedge clk); chk("exc_flush_end", 32'(flush), 32'h0); nxt();

        // Deferred ERET; later excp inputs carry junk that must be ignored.
        ev = 1; eret = 1; epc = 32'h80001234; s_mem = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("defer_stall", 32'(stall), 32'h1F);
            chk("defer_noflush", 32'(flush), 32'h0);
            nxt();
            eret = 0; epc = 32'hDEADBEEF; s_ex = 1;
        end
        ev = 0; s_mem = 0; @(negedge clk);
        chk("defer_flush", 32'(flush), 32'h1);
        chk("defer_pc", new_pc, 32'h80001234);
        chk("defer_stall0", 32'(stall), 32'h0);
        nxt();
        s_ex = 0; @(negedge clk); chk("defer_flush_end", 32'(flush), 32'h0); nxt();

        // Counter wrap: preload all-ones, one stalled cycle rolls to zero.
        force dut.cyc_q = 32'hFFFFFFFF;
        m_cyc = 32'hFFFFFFFF;
        #1 release dut.cyc_q;
        s_if = 1; @(negedge clk); chk("cyc_preload", cycles, 32'hFFFFFFFF); nxt();
        s_if = 0; @(negedge clk); chk("cyc_wrap", cycles, 32'h0); nxt();

        // Reset in DEFER discards the pending exception.
        ev = 1; eret = 0; s_mem = 1; @(negedge clk); nxt();
        ev = 0; s_mem = 0; rst = 1; @(negedge clk); chk("rst_defer_flush", 32'(flush), 32'h0); nxt();
        rst = 0; @(negedge clk);
        chk("post_rst_flush", 32'(flush), 32'h0);
        chk("post_rst_stall", 32'(stall), 32'h0);
        nxt();

        s_ex = 1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("wdog", 32'(tout), (c >= 5) ? 32'h1 : 32'h0);
            nxt();
        end
        s_ex = 0;
        nxt(); nxt();
        @(negedge clk); chk("wdog_sticky", 32'(tout), 32'h1); nxt();
        rst = 1; nxt();
        @(negedge clk); chk("wdog_rst", 32'(tout), 32'h0); nxt();
        rst = 0; nxt();

        chk("flush_count", 32'(d_nflush), 32'd2);
        chk("flush_count_model", 32'(d_nflush), 32'(m_nflush));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
